md_issue_ctrl: RTL and testbench

Sequencing controller for the shared HI/LO multiply/divide datapath in the E stage. It does four things:
- decodes the E-stage HI/LO operation and launches the datapath;
- counts the fixed multi-cycle latency, then issues the single HI/LO commit strobe;
- generates the D-stage stall for any HI/LO instruction while the unit is occupied;
- kills operations hit by an exception/interrupt flush.

---
 rtl/md_issue_ctrl.sv | 88 ++++++++
 tb/tb_md_issue_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// HI/LO multiply/divide issue controller: launches the shared datapath, times its latency,
// commits HI/LO and stalls D-stage HI/LO ops. Optional MD_FLUSH_ABORT_EN lets a flush abort an in-flight op.
module md_issue_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CW          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [3:0] e_op,
    input  logic       e_rt_zero,
    input  logic       d_md_use,
    output logic       stall_d,
    output logic       busy,
    output logic       dp_start,
    output logic [1:0] dp_op,
    output logic       hi_we,
    output logic       lo_we,
    output logic       hilo_we,
    output logic       md_done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          div0;

    logic is_md_op;
    logic is_div_op;
    logic start;
    logic last;
    logic abort;

    assign is_md_op  = (e_op >= 4'd1) && (e_op <= 4'd4);
    assign is_div_op = (e_op == 4'd3) || (e_op == 4'd4);
    assign busy      = (state == RUN);
    assign start     = !reset && is_md_op && !flush && (state == IDLE);
    assign last      = busy && (cnt == CW'(1));

`ifdef MD_FLUSH_ABORT_EN
    assign abort = busy && flush;
`else
    assign abort = 1'b0;
`endif

    // Datapath launch and same-cycle strobes; everything is quiet in a reset cycle.
    assign dp_start = start;
    assign dp_op    = start ? 2'(e_op - 4'd1) : 2'd0;
    assign md_done  = !reset && last && !abort;
    assign hilo_we  = md_done && !div0;
    assign hi_we    = !reset && (e_op == 4'd7) && !flush && !busy;
    assign lo_we    = !reset && (e_op == 4'd8) && !flush && !busy;
    // The start term is intentionally not qualified by flush.
    assign stall_d  = !reset && d_md_use && (busy || is_md_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            div0  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        div0  <= is_div_op && e_rt_zero;
                    end
                end
                RUN: begin
                    if (abort || last) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: timestamp-based occupancy model, directed cases and random traffic.
module tb_md_issue_ctrl;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;
    localparam int unsigned CW = 4;

    logic       clk = 1'b0;
    logic       reset, flush, e_rt_zero, d_md_use;
    logic [3:0] e_op;
    logic       stall_d, busy, dp_start, hi_we, lo_we, hilo_we, md_done;
    logic [1:0] dp_op;

    int tests = 0;
    int fails = 0;

    // Model: an op started in cycle T with latency N occupies T+1..T+N and completes in T+N.
    bit m_have;
    int m_end;
    bit m_div0;
    int cyc;

    logic s_stall, s_busy, s_start, s_hi, s_lo, s_hilo, s_done;
    logic [1:0] s_op;

    always #5 clk = ~clk;

    md_issue_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CW(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .e_op(e_op), .e_rt_zero(e_rt_zero),
        .d_md_use(d_md_use), .stall_d(stall_d), .busy(busy), .dp_start(dp_start),
        .dp_op(dp_op), .hi_we(hi_we), .lo_we(lo_we), .hilo_we(hilo_we), .md_done(md_done)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Drives one cycle, checks all outputs against the model mid-cycle, then advances the model.
    task automatic step(input logic r, input logic f, input logic [3:0] op,
                        input logic rz, input logic dm);
        bit is_md, st, dn, ab;
        reset = r; flush = f; e_op = op; e_rt_zero = rz; d_md_use = dm;
        is_md = (op >= 1) && (op <= 4);
        assert (r || !(m_have && is_md)) else $error("start issued while unit occupied");
        @(negedge clk);
        st = !r && is_md && !f && !m_have;
        ab = 1'b0;
`ifdef MD_FLUSH_ABORT_EN
        ab = m_have && f;
`endif
        dn = !r && m_have && (cyc == m_end) && !ab;
        chk("busy", 8'(busy), 8'(m_have));
        chk("dp_start", 8'(dp_start), 8'(st));
        chk("dp_op", 8'(dp_op), st ? 8'(op - 4'd1) : 8'd0);
        chk("md_done", 8'(md_done), 8'(dn));
        chk("hilo_we", 8'(hilo_we), 8'(dn && !m_div0));
        chk("stall_d", 8'(stall_d), 8'(!r && dm && (m_have || is_md)));
        chk("hi_we", 8'(hi_we), 8'(!r && op == 4'd7 && !f && !m_have));
        chk("lo_we", 8'(lo_we), 8'(!r && op == 4'd8 && !f && !m_have));
        s_stall = stall_d; s_busy = busy; s_start = dp_start; s_op = dp_op;
        s_hi = hi_we; s_lo = lo_we; s_hilo = hilo_we; s_done = md_done;
        @(posedge clk);
        if (r) m_have = 1'b0;
        else if (m_have && (cyc == m_end || ab)) m_have = 1'b0;
        else if (st) begin
            m_have = 1'b1;
            m_end  = cyc + ((op <= 4'd2) ? int'(MC) : int'(DC));
            m_div0 = (op >= 4'd3) && rz;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] op;
        reset = 1'b1; flush = 1'b0; e_op = 4'd0; e_rt_zero = 1'b0; d_md_use = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_have = 1'b0; m_end = 0; m_div0 = 1'b0; cyc = 0;

        // Reset values
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("rst_busy", 8'(s_busy), 8'd0);
        chk("rst_stall", 8'(s_stall), 8'd0);
        chk("rst_done", 8'(s_done), 8'd0);
        idle(1);

        // mult: busy T+1..T+5, commit only at T+5
        step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
        chk("mult_start", 8'(s_start), 8'd1);
        chk("mult_op", 8'(s_op), 8'd0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
            chk("mult_busy", 8'(s_busy), 8'd1);
            chk("mult_hilo", 8'(s_hilo), 8'(k == 5));
        end
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("mult_after", 8'(s_busy), 8'd0);

        // divu by zero: completes but never commits
        step(1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
        chk("divu_op", 8'(s_op), 8'd3);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
            chk("divz_busy", 8'(s_busy), 8'd1);
            chk("divz_done", 8'(s_done), 8'(k == 10));
            chk("divz_hilo", 8'(s_hilo), 8'd0);
        end

        // div with mflo waiting in D: stall T..T+10
        step(1'b0, 1'b0, 4'd3, 1'b0, 1'b1);
        chk("div_stall0", 8'(s_stall), 8'd1);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
            chk("div_stall", 8'(s_stall), 8'(k <= 10));
        end

        // mtlo with/without flush, mthi while busy
        step(1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
        chk("mtlo_flush", 8'(s_lo), 8'd0);
        step(1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
        chk("mtlo", 8'(s_lo), 8'd1);
        step(1'b0, 1'b0, 4'd7, 1'b0, 1'b0);
        chk("mthi", 8'(s_hi), 8'd1);
        step(1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd7, 1'b0, 1'b0);
        chk("mthi_busy", 8'(s_hi), 8'd0);
        idle(6);

        // flush in start cycle: no start, stall still pulses
        step(1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        chk("flush_start", 8'(s_start), 8'd0);
        chk("flush_stall", 8'(s_stall), 8'd1);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("flush_nobusy", 8'(s_busy), 8'd0);

        // mult with flush at T+3
        step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, (k == 3), 4'd0, 1'b0, 1'b0);
`ifdef MD_FLUSH_ABORT_EN
            chk("abort_busy", 8'(s_busy), 8'(k <= 3));
            chk("abort_hilo", 8'(s_hilo), 8'd0);
`else
            chk("noabort_busy", 8'(s_busy), 8'(k <= 5));
            chk("noabort_hilo", 8'(s_hilo), 8'(k == 5));
`endif
        end

        // div with reset at T+4, new mult at T+6
        step(1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("rstrun_done", 8'(s_done), 8'd0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("rstrun_busy", 8'(s_busy), 8'd0);
        chk("rstrun_hilo", 8'(s_hilo), 8'd0);
        step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
        chk("rstrun_restart", 8'(s_start), 8'd1);
        idle(6);

        // Random traffic obeying the no-issue-while-busy protocol
        for (int i = 0; i < 3000; i++) begin
            op = 4'($urandom_range(0, 15));
            if (m_have && op >= 4'd1 && op <= 4'd8) op = 4'd0;
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 7) == 0), op,
                 ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
